// File: rtl/set_assoc_cache.sv
// Write-through, no-write-allocate set-associative cache (1 or 2 ways, LRU) with coherence invalidate.
// Read hit completes 2 cycles after acceptance; accepts one request at a time (ready only in IDLE), stalls on mem_req_ready.
module set_assoc_cache #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int WORDS  = 2,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_req_valid,
    output logic                     cpu_req_ready,
    input  logic                     cpu_req_we,
    input  logic [ADDR_W-1:0]        cpu_req_addr,
    input  logic [DATA_W-1:0]        cpu_req_wdata,
    output logic                     cpu_resp_valid,
    output logic [DATA_W-1:0]        cpu_resp_data,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [DATA_W-1:0]        mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic [DATA_W*WORDS-1:0]  mem_resp_data,
    input  logic                     inv_valid,
    input  logic [ADDR_W-1:0]        inv_addr,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = DATA_W * WORDS;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        RESPOND
    } state_t;

    state_t state, state_nxt;

    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [LINE_W-1:0] data_q  [WAYS][SETS];

    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              victim_q;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  inv_idx;
    logic [TAG_W-1:0]  inv_tag;
    logic              unused_inv_off;

    assign req_off        = req_addr[OFF_W-1:0];
    assign req_idx        = req_addr[OFF_W +: IDX_W];
    assign req_tag        = req_addr[ADDR_W-1 -: TAG_W];
    assign inv_idx        = inv_addr[OFF_W +: IDX_W];
    assign inv_tag        = inv_addr[ADDR_W-1 -: TAG_W];
    assign unused_inv_off = ^inv_addr[OFF_W-1:0];

    logic              hit_any;
    logic              hit;
    logic              hit_way;
    logic              inv_hits_req;
    logic              victim;
    logic [DATA_W-1:0] hit_word;
    logic [DATA_W-1:0] fill_word;
    logic              fill;
    logic              write_hit;

    // A concurrent invalidate of the looked-up line turns a hit into a miss.
    always_comb begin
        hit_any      = 1'b0;
        hit_way      = 1'b0;
        inv_hits_req = inv_valid && (inv_idx == req_idx) && (inv_tag == req_tag);
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = w[0];
            end
        end
        hit = hit_any && !inv_hits_req;

        if (WAYS == 1)
            victim = 1'b0;
        else if (!valid_q[0][req_idx])
            victim = 1'b0;
        else if (!valid_q[WAYS-1][req_idx])
            victim = 1'b1;
        else
            victim = lru_q[req_idx];

        hit_word  = data_q[hit_way][req_idx][int'(req_off)*DATA_W +: DATA_W];
        fill_word = mem_resp_data[int'(req_off)*DATA_W +: DATA_W];
        fill      = (state == MEM_WAIT) && mem_resp_valid && !req_we;
        write_hit = (state == LOOKUP) && req_we && hit;
    end

    always_comb begin
        state_nxt      = state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        mem_req_valid  = 1'b0;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid)
                    state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (!req_we && hit)
                    state_nxt = RESPOND;
                else
                    state_nxt = MEM_REQ;
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_resp_valid)
                    state_nxt = RESPOND;
            end
            RESPOND: begin
                cpu_resp_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            for (int w = 0; w < WAYS; w++)
                valid_q[w] <= '0;
            lru_q         <= '0;
            req_we        <= 1'b0;
            req_addr      <= '0;
            req_wdata     <= '0;
            victim_q      <= 1'b0;
            cpu_resp_data <= '0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && cpu_req_valid) begin
                req_we    <= cpu_req_we;
                req_addr  <= cpu_req_addr;
                req_wdata <= cpu_req_wdata;
            end

            if (state == LOOKUP) begin
                if (hit)
                    lru_q[req_idx] <= ~hit_way;
                if (req_we) begin
                    mem_req_we    <= 1'b1;
                    mem_req_addr  <= req_addr;
                    mem_req_wdata <= req_wdata;
                end else if (hit) begin
                    cpu_resp_data <= hit_word;
                    if (hit_count != 16'hFFFF)
                        hit_count <= hit_count + 16'd1;
                end else begin
                    victim_q     <= victim;
                    mem_req_we   <= 1'b0;
                    mem_req_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (miss_count != 16'hFFFF)
                        miss_count <= miss_count + 16'd1;
                end
            end

            if (fill) begin
                lru_q[req_idx] <= ~victim_q;
                cpu_resp_data  <= fill_word;
            end

            if (inv_valid) begin
                for (int w = 0; w < WAYS; w++)
                    if (tag_q[w][inv_idx] == inv_tag)
                        valid_q[w][inv_idx] <= 1'b0;
            end

            // The fill's new tag is not yet in tag_q, so the invalidate race is resolved here.
            if (fill)
                valid_q[victim_q][req_idx] <= !inv_hits_req;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && fill) begin
            tag_q[victim_q][req_idx]  <= req_tag;
            data_q[victim_q][req_idx] <= mem_resp_data;
        end else if (reset && write_hit) begin
            data_q[hit_way][req_idx][int'(req_off)*DATA_W +: DATA_W] <= req_wdata;
        end
    end

endmodule
